// File: rtl/stream_mux_rr.sv
// stream_mux_rr: 2**SIZE-channel valid/ready stream multiplexer.
// Round-robin arbitration picks one producer per beat. With LOCK=1 the grant
// is held from the first beat of a packet until its last beat. One registered
// output stage gives a 1-cycle input-to-output latency and full throughput
// while out_ready stays high.
module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int SIZE  = 2,
  parameter  int LOCK  = 1,
  localparam int N     = 2 ** SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH*N-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [SIZE-1:0]    out_select,
  output logic               locked
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Lock FSM state
  state_e          state_q;
  logic [SIZE-1:0] lock_ch_q;
  logic            locked_q;

  // Output stage and arbitration pointer
  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             out_valid_q,  out_valid_d;
  logic             out_last_q,   out_last_d;
  logic [SIZE-1:0]  out_select_q, out_select_d;
  logic [SIZE-1:0]  rr_ptr_q,     rr_ptr_d;

  // Arbitration results
  logic             load_en;
  logic [SIZE-1:0]  grant;
  logic             granted;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  // The output register can take a new beat when empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  // Pick the channel allowed to load: the locked channel mid-packet,
  // otherwise the first valid channel at or after rr_ptr (wrapping).
  always_comb begin
    logic [SIZE-1:0] cand;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant   = rr_ptr_q;
    granted = 1'b0;
    cand    = '0;
    if (state_q == ST_LOCKED) begin
      grant   = lock_ch_q;
      granted = 1'b1;
    end else begin
      // Walk from the farthest offset down so the nearest valid channel wins.
      for (int off = N - 1; off >= 0; off--) begin
        cand = rr_ptr_q + SIZE'(off);
        if (in_valid[cand]) begin
          grant   = cand;
          granted = 1'b1;
        end
      end
    end
  end

  // Only the granted channel sees ready, and nothing is accepted in reset.
  always_comb begin
    in_ready = '0;
    if (!reset && load_en && granted) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign xfer     = |(in_ready & in_valid);
  assign sel_data = in_data[int'(grant)*WIDTH +: WIDTH];
  assign sel_last = in_last[grant];

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_select_d = out_select_q;
    rr_ptr_d     = rr_ptr_q;
    if (load_en) begin
      // Drain leaves data/last/select untouched; only valid drops.
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d   = sel_data;
        out_last_d   = sel_last;
        out_select_d = grant;
      end
    end
    if (xfer && (LOCK == 0 || sel_last)) begin
      // N is a power of two, so the SIZE-bit add wraps N-1 back to 0.
      rr_ptr_d = grant + 1'b1;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_select_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_select_q <= out_select_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // Packet lock FSM: enter LOCKED on a non-last beat, leave on the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= '0;
      locked_q  <= 1'b0;
    end else if (LOCK != 0 && xfer) begin
      case (state_q)
        ST_IDLE: begin
          if (!sel_last) begin
            state_q   <= ST_LOCKED;
            lock_ch_q <= grant;
            locked_q  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          // While locked, grant can only be lock_ch_q.
          if (sel_last) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_select = out_select_q;
  assign locked     = locked_q;

  // At most one producer is offered ready at a time.
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(in_ready));

  // Without packet locking the FSM never leaves IDLE.
  a_no_lock_when_disabled: assert property (@(posedge clk) disable iff (reset)
    (LOCK != 0) || !locked_q);

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the combinational Mux family: a 2**SIZE-channel stream multiplexer with valid/ready handshakes, round-robin arbitration, optional packet locking and one registered output stage.
- Sits between several producers and one consumer (bus/port sharing).
- Replaces the static select input with internally generated, fair grant selection.

Parameters:
- WIDTH, 8, data bits per channel.
- SIZE, 2, select width; channel count N = 2**SIZE (SIZE >= 1).
- LOCK, 1, 1 = hold grant from first beat until a beat with last=1; 0 = re-arbitrate every beat.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH*N  packed channel data; channel i at bits [i*WIDTH +: WIDTH], channel 0 at LSBs.
- in_valid  in  N  per-channel valid.
- in_last  in  N  per-channel end-of-packet flag; qualified by in_valid.
- in_ready  out  N  per-channel ready, combinational.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  registered valid.
- out_last  out  1  registered last flag.
- out_ready  in  1  consumer ready.
- out_select  out  SIZE  channel index of the current out_data beat.
- locked  out  1  high while mid-packet with LOCK=1.

Behaviour:
- Reset, asynchronous and active-high: out_valid=0, out_data=0, out_last=0, out_select=0, locked=0, rr_ptr=0.
  - in_ready is forced to all zeros while reset is high.
- load_en = !out_valid || out_ready. This gives full throughput of 1 beat/cycle with no bubble under continuous out_ready.
- Arbitration, combinational:
  - If locked, grant = lock_ch.
  - Otherwise, grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N.
  - No valid channel means no grant.
- in_ready[i] = load_en && granted && (grant == i). At most one bit is ever high.
- Transfer on channel g: in_valid[g] && in_ready[g] at a rising edge.
  - Next cycle: out_data = in_data[g], out_last = in_last[g], out_select = g, out_valid = 1.
  - Latency is exactly 1 cycle input to output.
- Drain: if load_en=1 and there is no transfer, out_valid goes to 0 at the next edge. out_data, out_last and out_select hold their values.
- Stall: if out_valid=1 and out_ready=0, all outputs hold and in_ready=0.
- rr_ptr update:
  - LOCK=0: after every transfer, rr_ptr = (g+1) mod N.
  - LOCK=1: rr_ptr = (g+1) mod N only on a transfer with in_last[g]=1.
  - No transfer: rr_ptr holds.
- Lock FSM, LOCK=1 only, with states IDLE and LOCKED:
  - IDLE -> LOCKED on a transfer with last=0; lock_ch = g.
  - LOCKED -> IDLE on a transfer from lock_ch with last=1.
  - In LOCKED, other channels get no grant even when lock_ch deasserts in_valid; bubbles are allowed.
  - A single-beat packet (last=1 on the first beat) stays in IDLE.
  - locked = (state == LOCKED).
- With LOCK=0: state stays IDLE, locked=0, and in_last is passed through only.
- Wrap-around: the pointer wraps from N-1 to 0. With N valid channels held high, grants cycle 0,1,...,N-1,0.
- Reset mid-packet: the lock is dropped, the pointer returns to 0, and any output beat is discarded. The next cycle after reset release arbitrates from channel 0.
- Width rule: out_select is exactly SIZE bits and requires no truncation.

Test Plan:
1. WIDTH=3, SIZE=2, LOCK=0; all in_valid=4'b1111, data ch0..3 = 0,1,2,3; out_ready=1 -> out_data sequence 0,1,2,3,0,1 on consecutive cycles with out_select matching; first out_valid one cycle after reset release.
2. Only ch3 valid with data 3'b011, out_ready=1 -> out_data=3'b011, out_select=3 every cycle; rr_ptr wraps to 0 after each beat.
3. LOCK=1; ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 are held valid -> three consecutive ch1 beats, locked=1 during beats 1-2 transfers; next grant goes to ch2, then ch0.
4. LOCK=1; ch1 locked, ch1 in_valid drops for 2 cycles while ch2 is valid -> out_valid=0 bubbles, in_ready[2]=0 throughout; ch1 resumes and completes before ch2 is granted.
5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data, out_select and out_last held, in_ready=4'b0000; on out_ready=1 a new beat follows the next cycle with no loss or duplication.
6. Assert reset mid-packet with LOCK=1 while ch2 is locked -> out_valid=0, locked=0 immediately; after release with all channels valid, the first grant is ch0.
